click_sync_receiver: RTL
========================

// Module: click_sync_receiver
// PURPOSE
//   Terminating end of a click pipeline: consumes drive/free handshakes from a click stage (e.g. the
//   o_driveNext/i_freeNext pair of a cFifo1 chain) and hands words to clocked logic over valid/ready.
//   Synchronises drive events into clk, buffers words in a DEPTH-entry FIFO, and returns free
//   pulses upstream only while buffer space exists (credit back-pressure).
// PARAMETERS
//   WIDTH        32  data word width
//   DEPTH         4  FIFO entries, power of two, >=2
//   SYNC_STAGES   2  synchroniser flops on drive phase, >=2
//   FREE_CYCLES   2  o_free high time in clk cycles, >=1
// PORTS
//   clk       in   1            single clock
//   rst       in   1            asynchronous, active-low reset
//   i_drive   in   1            click drive event; rising edge = new word on i_data
//   i_data    in   WIDTH        bundled data, stable from i_drive rise until o_free rise
//   o_free    out  1            free pulse upstream; rising edge acknowledges word
//   o_valid   out  1            FIFO head valid
//   o_data    out  WIDTH        FIFO head word
//   i_ready   in   1            consumer accepts head when o_valid & i_ready at clk rise
//   o_count   out  $clog2(DEPTH)+1  words held
// BEHAVIOUR
//   Reset (rst=0, async): phase toggle, sync chain, edge flop, FIFO ptrs/count, free FSM cleared;
//     o_free=0, o_valid=0, o_data=0, o_count=0. In-flight drive is discarded; upstream shares rst.
//   Capture: drive_phase toggles on every i_drive rising edge (flop clocked by i_drive, async rst).
//     Phase passes SYNC_STAGES flops into clk; event = sync_out XOR last_sync (1-cycle strobe).
//   Write: on event cycle, i_data written at wptr; count+1. i_data is stable >=SYNC_STAGES cycles
//     by then, so sampling is safe. Event never arrives with FIFO full (see credits).
//   Read: o_valid = (count!=0); o_data = mem[rptr] (registered head, valid same cycle as o_valid).
//     Pop on o_valid & i_ready: rptr+1, count-1. Pointers wrap modulo DEPTH.
//   Simultaneous write+pop: count unchanged, both pointers advance.
//   Latency: i_drive rise -> event at clk edge SYNC_STAGES+1 -> o_valid high next cycle.
//   Free FSM states: IDLE, PEND, PULSE.
//     IDLE: on event -> PULSE if count_after_write < DEPTH, else PEND.
//     PEND: wait for pop (count drops below DEPTH) -> PULSE next cycle.
//     PULSE: o_free=1 for exactly FREE_CYCLES cycles, then IDLE.
//   o_free registered, glitch-free; at most one outstanding word upstream (click protocol), so
//     event in PULSE/PEND is a protocol violation: flagged by simulation assertion, not handled.
//   Word becoming full: 4th write with DEPTH=4 holds free in PEND until consumer pops.
//   Empty with i_ready=1: no pop, count stays 0. Reset mid-PULSE drops o_free immediately.
// TESTING
//   1 Reset: rst=0 mid-traffic -> o_free=0, o_valid=0, o_count=0 same instant; no spurious event after release.
//   2 Single word: i_drive rise, i_data=0xA5A5_0001, i_ready=1 -> o_valid at clk edge 4 (SYNC_STAGES=2),
//     o_data=0xA5A5_0001, o_free high exactly 2 cycles starting edge 4.
//   3 Fill: i_ready=0, send 4 words 1..4 -> o_count=4, free pulses after words 1-3 only, FSM in PEND;
//     pop one -> o_free pulse next cycle; 5th word accepted, pops yield 1,2,3,4,5 in order.
//   4 Wrap: 10 words with random i_ready stalls -> pointer wrap, order preserved, o_count never >4.
//   5 Concurrent: write event and pop same cycle at count=2 -> count stays 2, data order intact.
//   6 Async phase: i_drive edges at random offsets vs clk (8 offsets within one period) -> no lost/duplicate words.

Source files
------------

// File: rtl/click_sync_receiver_if.sv
// click_sync_receiver_if: click drive/free handshake plus consumer valid/ready bus
interface click_sync_receiver_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic             i_drive;
  logic [WIDTH-1:0] i_data;
  logic             o_free;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             i_ready;
  logic [CW-1:0]    o_count;
  modport master (output i_drive, i_data, i_ready, input o_free, o_valid, o_data, o_count);
  modport slave  (input i_drive, i_data, i_ready, output o_free, o_valid, o_data, o_count);
endinterface

// File: rtl/click_sync_receiver.sv
// click_sync_receiver: synchronises click drive events into clk, buffers words, returns free credits
module click_sync_receiver #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FREE_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  click_sync_receiver_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FREE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, PEND, PULSE} state_t;
  logic                   phase_q, phase_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   last_q, last_d;
  logic                   ev_q, ev_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [WIDTH-1:0]       mem_d [DEPTH];
  logic [AW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]          count_q, count_d;
  state_t                 state_q, state_d;
  logic [FW-1:0]          cnt_q, cnt_d;
  logic                   free_q, free_d;
  logic                   pop;

  assign phase_d = ~phase_q;

  // drive-domain phase toggle, one flip per click event
  always_ff @(posedge bus.i_drive or negedge rst)
    if (!rst) phase_q <= 1'b0;
    else phase_q <= phase_d;

  // synchroniser, registered event strobe and FIFO datapath
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], phase_q};
    last_d  = sync_q[SYNC_STAGES-1];
    ev_d    = sync_q[SYNC_STAGES-1] ^ last_q;
    pop     = (count_q != '0) & bus.i_ready;
    mem_d   = mem_q;
    if (ev_q) mem_d[wptr_q] = bus.i_data;
    wptr_d  = wptr_q + AW'(ev_q);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(ev_q) - CW'(pop);
  end

  // free FSM: credit goes back only while a slot remains after this word
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (ev_q) state_d = (count_d < CW'(DEPTH)) ? PULSE : PEND;
      PEND:    if (count_d < CW'(DEPTH)) state_d = PULSE;
      PULSE:   if (cnt_q == '0) state_d = IDLE; else cnt_d = cnt_q - FW'(1);
      default: state_d = IDLE;
    endcase
    if (state_d == PULSE && state_q != PULSE) cnt_d = FW'(FREE_CYCLES - 1);
    free_d = (state_d == PULSE);
  end

  // clk-domain state registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync_q  <= '0;
      last_q  <= 1'b0;
      ev_q    <= 1'b0;
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      free_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      last_q  <= last_d;
      ev_q    <= ev_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      free_q  <= free_d;
    end

  assign bus.o_free  = free_q;
  assign bus.o_valid = (count_q != '0);
  assign bus.o_data  = mem_q[rptr_q];
  assign bus.o_count = count_q;

  // upstream holds at most one word, so a new event can only land once the credit was returned
  assert property (@(posedge clk) disable iff (!rst) ev_q |-> state_q == IDLE);
endmodule
